light_phase_sequencer: RTL and testbench



---
 rtl/light_phase_sequencer.sv | 100 ++++++++++
 tb/tb_light_phase_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/light_phase_sequencer.sv
// Timed RED -> GREEN -> YELLOW -> RED phase generator for one approach.
// Presents the current colour, the seconds left in that phase and a one-cycle pulse on each change.
module light_phase_sequencer #(
  parameter int RED_TIME    = 20,
  parameter int GREEN_TIME  = 15,
  parameter int YELLOW_TIME = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       hold,
  input  logic       restart,
  output logic [1:0] light,
  output logic [4:0] lightTime,
  output logic       phaseDone
);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_YELLOW = 2'b01,
    S_GREEN  = 2'b10
  } state_t;

  localparam int DURATIONS [3] = '{RED_TIME, GREEN_TIME, YELLOW_TIME};

  // A duration outside 1..31 cannot be represented by the 5-bit countdown, so refuse to elaborate.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dur_check
      if (DURATIONS[gi] < 1 || DURATIONS[gi] > 31) begin : g_bad_dur
        $error("light_phase_sequencer: phase duration %0d outside 1..31", DURATIONS[gi]);
      end
    end
  endgenerate

  localparam logic [4:0] RED_T    = 5'(RED_TIME);
  localparam logic [4:0] GREEN_T  = 5'(GREEN_TIME);
  localparam logic [4:0] YELLOW_T = 5'(YELLOW_TIME);

  state_t     state_reg;
  logic [4:0] time_reg;
  logic       done_reg;
  logic       advance;
  logic       expire;

  assign advance = tick & enable & ~hold;
  assign expire  = (time_reg <= 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RED;
      time_reg  <= RED_T;
      done_reg  <= 1'b0;
    end else if (restart) begin
      state_reg <= S_RED;
      time_reg  <= RED_T;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // Countdown only ever decrements from 2 or more, so it never reaches 0.
      if (advance && !expire) begin
        time_reg <= time_reg - 5'd1;
      end
      case (state_reg)
        S_RED: begin
          if (advance && expire) begin
            state_reg <= S_GREEN;
            time_reg  <= GREEN_T;
            done_reg  <= 1'b1;
          end
        end
        S_GREEN: begin
          if (advance && expire) begin
            state_reg <= S_YELLOW;
            time_reg  <= YELLOW_T;
            done_reg  <= 1'b1;
          end
        end
        S_YELLOW: begin
          if (advance && expire) begin
            state_reg <= S_RED;
            time_reg  <= RED_T;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          // Unused encoding: fall back to the start of RED without a pulse.
          state_reg <= S_RED;
          time_reg  <= RED_T;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign light     = state_reg;
  assign lightTime = time_reg;
  assign phaseDone = done_reg;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Bench for light_phase_sequencer: default instance plus a YELLOW_TIME=1 instance on shared inputs,
// both checked against a phase-table model, with vector table, corner sequences and random traffic.
module tb_light_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, enable = 1'b0, hold = 1'b0, restart = 1'b0;
  logic [1:0] light0, light1;
  logic [4:0] time0, time1;
  logic       done0, done1;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  always #5 clk = ~clk;

  light_phase_sequencer u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .hold(hold), .restart(restart),
    .light(light0), .lightTime(time0), .phaseDone(done0)
  );

  light_phase_sequencer #(.RED_TIME(20), .GREEN_TIME(15), .YELLOW_TIME(1)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .hold(hold), .restart(restart),
    .light(light1), .lightTime(time1), .phaseDone(done1)
  );

  // Model: phase index 0=RED,1=GREEN,2=YELLOW walks a duration table per instance.
  int         dur [2][3] = '{'{20, 15, 3}, '{20, 15, 1}};
  logic [1:0] colour [3] = '{2'b00, 2'b10, 2'b01};
  int         m_ph [2];
  int         m_rem [2];
  int         m_done [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_rem[k] = dur[k][0]; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input logic t, input logic e, input logic h, input logic r);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (r) begin
        m_ph[k] = 0; m_rem[k] = dur[k][0];
      end else if (t && e && !h) begin
        if (m_rem[k] > 1) m_rem[k]--;
        else begin
          m_ph[k] = (m_ph[k] + 1) % 3; m_rem[k] = dur[k][m_ph[k]]; m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (txn %0d)", name, act, exp, txn);
    end
  endtask

  task automatic check_model();
    chk("dut0_light", light0, colour[m_ph[0]]);
    chk("dut0_time",  time0,  m_rem[0]);
    chk("dut0_done",  done0,  m_done[0]);
    chk("dut1_light", light1, colour[m_ph[1]]);
    chk("dut1_time",  time1,  m_rem[1]);
    chk("dut1_done",  done1,  m_done[1]);
  endtask

  task automatic apply(input logic t, input logic e, input logic h, input logic r);
    tick = t; enable = e; hold = h; restart = r;
    @(posedge clk); #1;
    model_step(t, e, h, r);
    txn++;
    $display("txn %0d t=%b e=%b h=%b r=%b | d0 %b/%0d/%b d1 %b/%0d/%b",
             txn, t, e, h, r, light0, time0, done0, light1, time1, done1);
    check_model();
  endtask

  task automatic do_reset();
    tick = 0; enable = 0; hold = 0; restart = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    txn++;
    $display("txn %0d reset | d0 %b/%0d/%b", txn, light0, time0, done0);
    check_model();
  endtask

  typedef struct {
    logic t, e, h, r;
    logic [1:0] l;
    logic [4:0] lt;
    logic d;
  } vec_t;

  vec_t vecs [11];
  int pulses;
  int min_time;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd20, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd19, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd19, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd19, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd18, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd18, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd20, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd19, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 5'd20, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd20, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd19, 1'b0};

    // Reset state, then the vector table.
    do_reset();
    chk("reset_light", light0, 0);
    chk("reset_time", time0, 20);
    chk("reset_done", done0, 0);
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].t, vecs[i].e, vecs[i].h, vecs[i].r);
      chk("vec_light", light0, vecs[i].l);
      chk("vec_time", time0, vecs[i].lt);
      chk("vec_done", done0, vecs[i].d);
    end

    // 20 ticks: RED counts down, then GREEN/15 with one pulse.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 0, 0);
      pulses += int'(done0);
    end
    chk("red_to_green_light", light0, 2);
    chk("red_to_green_time", time0, 15);
    chk("red_to_green_done", done0, 1);
    chk("red_to_green_pulses", pulses, 1);

    // Full 38-tick cycle.
    do_reset();
    pulses = 0; min_time = 31;
    for (int i = 0; i < 38; i++) begin
      apply(1, 1, 0, 0);
      pulses += int'(done0);
      if (int'(time0) < min_time) min_time = int'(time0);
    end
    chk("cycle_pulses", pulses, 3);
    chk("cycle_min_time_nonzero", int'(min_time > 0), 1);
    chk("cycle_end_light", light0, 0);
    chk("cycle_end_time", time0, 20);

    // Freeze by enable low then hold in GREEN at 7.
    do_reset();
    for (int i = 0; i < 28; i++) apply(1, 1, 0, 0);
    chk("green7_light", light0, 2);
    chk("green7_time", time0, 7);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin apply(1, 0, 0, 0); pulses += int'(done0); end
    for (int i = 0; i < 5; i++) begin apply(1, 1, 1, 0); pulses += int'(done0); end
    chk("frozen_time", time0, 7);
    chk("frozen_pulses", pulses, 0);
    apply(1, 1, 0, 0);
    chk("thawed_time", time0, 6);

    // Restart with expiry tick in YELLOW at 1.
    for (int i = 0; i < 8; i++) apply(1, 1, 0, 0);
    chk("yellow1_light", light0, 1);
    chk("yellow1_time", time0, 1);
    apply(1, 1, 0, 1);
    chk("restart_light", light0, 0);
    chk("restart_time", time0, 20);
    chk("restart_done", done0, 0);

    // Asynchronous reset between edges mid-GREEN at 9.
    do_reset();
    for (int i = 0; i < 26; i++) apply(1, 1, 0, 0);
    chk("green9_time", time0, 9);
    #2 rst = 1'b1;
    #1;
    chk("async_light", light0, 0);
    chk("async_time", time0, 20);
    chk("async_done", done0, 0);
    tick = 1; enable = 1;
    @(posedge clk); #1;
    chk("async_held_time", time0, 20);
    rst = 1'b0;
    model_reset();
    apply(1, 1, 0, 0);

    // YELLOW_TIME=1 instance: back-to-back expiries.
    do_reset();
    for (int i = 0; i < 34; i++) apply(1, 1, 0, 0);
    chk("y1_green_light", light1, 2);
    chk("y1_green_time", time1, 1);
    apply(1, 1, 0, 0);
    chk("y1_yellow_light", light1, 1);
    chk("y1_yellow_time", time1, 1);
    chk("y1_yellow_done", done1, 1);
    apply(1, 1, 0, 0);
    chk("y1_red_light", light1, 0);
    chk("y1_red_time", time1, 20);
    chk("y1_red_done", done1, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(logic'($urandom_range(1, 0)),
            logic'($urandom_range(9, 0) != 0),
            logic'($urandom_range(9, 0) == 0),
            logic'($urandom_range(49, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
